// File: rtl/pkt_frame_mux.sv
// Round-robin packet multiplexer: per-channel FIFOs feed one output, with each packet granted atomically.
// Define PKT_FRAME_MUX_CNT_EN to add per-channel completed-packet counters on pkt_cnt.
//
// state | meaning
// IDLE  | no grant held; picks the first non-empty channel from rrPtr upward
// LOCK  | grant held until the granted packet's last word is read
module pkt_frame_mux #(
    parameter int N_CH   = 2,
    parameter int WORD_W = 64,
    parameter int DEPTH  = 16,
    localparam int KEEP_W = WORD_W / 8,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [N_CH*WORD_W-1:0] in_data,
    input  logic [N_CH*KEEP_W-1:0] in_keep,
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic [KEEP_W-1:0]      out_keep,
    output logic                   out_last,
    output logic [CH_W-1:0]        out_ch
`ifdef PKT_FRAME_MUX_CNT_EN
    ,
    output logic [N_CH*32-1:0]     pkt_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = WORD_W + KEEP_W + 1;
    localparam logic [AW:0]     PTR_ONE = 1;
    localparam logic [CH_W-1:0] CH_ONE  = 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t state, stateNext;
    logic [CH_W-1:0] grant, grantNext, rrPtr, rrPtrNext, pick;
    logic found;

    logic [EW-1:0] mem [N_CH][DEPTH];
    logic [AW:0] wrPtr [N_CH];
    logic [AW:0] rdPtr [N_CH];
    logic [N_CH-1:0] full, empty, wrEn, rdEn;
    logic [N_CH-1:0][EW-1:0] head;
    logic [EW-1:0] headSel;
    logic outValid, rdFire, headLast;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            empty[c] = (wrPtr[c] == rdPtr[c]);
            full[c]  = (wrPtr[c][AW] != rdPtr[c][AW]) &&
                       (wrPtr[c][AW-1:0] == rdPtr[c][AW-1:0]);
            wrEn[c]  = in_valid[c] && !full[c];
            head[c]  = mem[c][rdPtr[c][AW-1:0]];
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            rdEn[c] = rdFire && (grant == CH_W'(c));
        end
    end

    assign in_ready = ~full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                wrPtr[c] <= '0;
                rdPtr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (wrEn[c]) wrPtr[c] <= wrPtr[c] + PTR_ONE;
                if (rdEn[c]) rdPtr[c] <= rdPtr[c] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (wrEn[c]) begin
                mem[c][wrPtr[c][AW-1:0]] <= {in_last[c],
                                             in_keep[c*KEEP_W +: KEEP_W],
                                             in_data[c*WORD_W +: WORD_W]};
            end
        end
    end

    assign headSel  = head[grant];
    assign headLast = headSel[EW-1];
    assign outValid = (state == LOCK) && !empty[grant];
    assign rdFire   = outValid && out_ready;

    // Round-robin search, wrapping modulo N_CH from rrPtr.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = rrPtr;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rrPtr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && !empty[idx[CH_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            rrPtr <= '0;
        end else begin
            state <= stateNext;
            grant <= grantNext;
            rrPtr <= rrPtrNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grant;
        rrPtrNext = rrPtr;
        case (state)
            IDLE: begin
                if (found) begin
                    stateNext = LOCK;
                    grantNext = pick;
                end
            end
            LOCK: begin
                if (rdFire && headLast) begin
                    stateNext = IDLE;
                    rrPtrNext = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_ONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Payload is zeroed whenever no word is offered, which also covers reset.
    assign out_valid = outValid;
    assign out_data  = outValid ? headSel[WORD_W-1:0] : '0;
    assign out_keep  = outValid ? headSel[WORD_W +: KEEP_W] : '0;
    assign out_last  = outValid && headLast;
    assign out_ch    = grant;

`ifdef PKT_FRAME_MUX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (rdEn[c] && headLast) begin
                    pkt_cnt[c*32 +: 32] <= pkt_cnt[c*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
